// File: rtl/rtob_pkg.sv
// Constants shared by the timed output queue: late-event policy encodings and sticky-error slot indices.
package rtob_pkg;

  localparam logic RTOB_LATE_DROP  = 1'b0;
  localparam logic RTOB_LATE_ISSUE = 1'b1;

  localparam int RTOB_ERR_OVF = 0;
  localparam int RTOB_ERR_TS  = 1;
  localparam int RTOB_ERR_ORD = 2;
  localparam int RTOB_ERR_NUM = 3;

endpackage

// File: rtl/rtob_timed_queue_if.sv
// Write handshake and dispatch bus of the timed output queue.
interface rtob_timed_queue_if #(
  parameter int DATA_LEN = 32,
  parameter int TS_LEN   = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [TS_LEN-1:0]   in_timestamp;
  logic [DATA_LEN-1:0] in_data;
  logic                out_valid;
  logic                out_late;
  logic [TS_LEN-1:0]   out_timestamp;
  logic [DATA_LEN-1:0] out_data;

  modport master (
    output in_valid, in_timestamp, in_data,
    input  in_ready, out_valid, out_late, out_timestamp, out_data
  );

  modport slave (
    input  in_valid, in_timestamp, in_data,
    output in_ready, out_valid, out_late, out_timestamp, out_data
  );
endinterface

// File: rtl/rtob_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: head visible the cycle after the write.
// Pushes when full and pops when empty are ignored; the caller owns backpressure.
module rtob_sync_fifo #(
  parameter int WIDTH    = 96,
  parameter int DEPTH    = 16,
  parameter int ADDR_LEN = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                push,
  input  logic [WIDTH-1:0]    wr_dat,
  input  logic                pop,
  output logic [WIDTH-1:0]    rd_dat,
  output logic [ADDR_LEN:0]   level
);
  localparam logic [ADDR_LEN:0] LVL_MAX = (ADDR_LEN+1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_LEN-1:0] wr_ptr;
  logic [ADDR_LEN-1:0] rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign push_ok = push && (level != LVL_MAX);
  assign pop_ok  = pop && (level != '0);
  assign rd_dat  = mem[rd_ptr];

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      level <= level + 1'b1;
      else if (!push_ok && pop_ok) level <= level - 1'b1;
    end
  end
endmodule

// File: rtl/rtob_timed_queue.sv
// Real-time output buffer: queues timestamped words and dispatches each one a cycle after the counter reaches it.
// in_ready drops at FULL_THRESHOLD from registered occupancy; late, out-of-order and overflowing entries raise sticky errors.
module rtob_timed_queue
  import rtob_pkg::*;
#(
  parameter int DATA_LEN       = 32,
  parameter int TS_LEN         = 64,
  parameter int DEPTH          = 16,
  parameter int ADDR_LEN       = $clog2(DEPTH),
  parameter int FULL_THRESHOLD = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       auto_start,
  input  logic                       late_mode,
  input  logic                       error_clear,
  input  logic [TS_LEN-1:0]          counter,
  rtob_timed_queue_if.slave          bus,
  output logic [ADDR_LEN:0]          level,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow_error,
  output logic                       timestamp_error,
  output logic                       order_error,
  output logic [TS_LEN+DATA_LEN-1:0] overflow_error_data,
  output logic [TS_LEN+DATA_LEN-1:0] timestamp_error_data,
  output logic [TS_LEN+DATA_LEN-1:0] order_error_data
);
  typedef struct packed {
    logic [TS_LEN-1:0]   ts;
    logic [DATA_LEN-1:0] data;
  } rtob_entry_t;

  localparam logic [ADDR_LEN:0] FULL_LVL = (ADDR_LEN+1)'(FULL_THRESHOLD);

  rtob_entry_t             head;
  rtob_entry_t             in_entry;
  logic [TS_LEN-1:0]       last_ts;
  logic                    last_ts_vld;
  logic                    order_violation;
  logic                    accept;
  logic                    have_head;
  logic                    hit;
  logic                    late;
  logic                    pop;
  logic                    issue;
  logic [RTOB_ERR_NUM-1:0] err_evt;
  logic [RTOB_ERR_NUM-1:0] err_flag;
  rtob_entry_t             err_src [RTOB_ERR_NUM];
  rtob_entry_t             err_dat [RTOB_ERR_NUM];

  assign in_entry     = '{ts: bus.in_timestamp, data: bus.in_data};
  assign full         = (level >= FULL_LVL);
  assign empty        = (level == '0);
  assign bus.in_ready = !full;

  // Equal timestamps are legal; only a strictly earlier one breaks ordering.
  assign order_violation = last_ts_vld && (bus.in_timestamp < last_ts);
  assign accept          = bus.in_valid && bus.in_ready && !order_violation;

  rtob_sync_fifo #(
    .WIDTH    ($bits(rtob_entry_t)),
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (accept),
    .wr_dat  (in_entry),
    .pop     (pop),
    .rd_dat  (head),
    .level   (level)
  );

  assign have_head = auto_start && !empty;
  assign hit       = have_head && (counter == head.ts);
  assign late      = have_head && (counter > head.ts);
  assign pop       = hit || late;
  assign issue     = hit || (late && (late_mode == RTOB_LATE_ISSUE));

  assign err_evt[RTOB_ERR_OVF] = bus.in_valid && !bus.in_ready;
  assign err_evt[RTOB_ERR_TS]  = late;
  assign err_evt[RTOB_ERR_ORD] = bus.in_valid && bus.in_ready && order_violation;
  assign err_src[RTOB_ERR_OVF] = in_entry;
  assign err_src[RTOB_ERR_TS]  = head;
  assign err_src[RTOB_ERR_ORD] = in_entry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ts     <= '0;
      last_ts_vld <= 1'b0;
    end else if (flush) begin
      last_ts     <= '0;
      last_ts_vld <= 1'b0;
    end else if (accept) begin
      last_ts     <= bus.in_timestamp;
      last_ts_vld <= 1'b1;
    end
  end

  // Dispatched entry is held on the bus until the next dispatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid     <= 1'b0;
      bus.out_late      <= 1'b0;
      bus.out_timestamp <= '0;
      bus.out_data      <= '0;
    end else if (flush) begin
      bus.out_valid     <= 1'b0;
      bus.out_late      <= 1'b0;
      bus.out_timestamp <= '0;
      bus.out_data      <= '0;
    end else begin
      bus.out_valid <= issue;
      if (issue) begin
        bus.out_late      <= late;
        bus.out_timestamp <= head.ts;
        bus.out_data      <= head.data;
      end
    end
  end

  // Capture only the first offender; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= '0;
      for (int i = 0; i < RTOB_ERR_NUM; i++) err_dat[i] <= '0;
    end else if (flush) begin
      err_flag <= '0;
      for (int i = 0; i < RTOB_ERR_NUM; i++) err_dat[i] <= '0;
    end else begin
      for (int i = 0; i < RTOB_ERR_NUM; i++) begin
        if (err_evt[i]) begin
          err_flag[i] <= 1'b1;
          if (!err_flag[i] || error_clear) err_dat[i] <= err_src[i];
        end else if (error_clear) begin
          err_flag[i] <= 1'b0;
        end
      end
    end
  end

  assign overflow_error       = err_flag[RTOB_ERR_OVF];
  assign timestamp_error      = err_flag[RTOB_ERR_TS];
  assign order_error          = err_flag[RTOB_ERR_ORD];
  assign overflow_error_data  = err_dat[RTOB_ERR_OVF];
  assign timestamp_error_data = err_dat[RTOB_ERR_TS];
  assign order_error_data     = err_dat[RTOB_ERR_ORD];
endmodule

// File: tb/tb_rtob_timed_queue.sv
// Scoreboard bench: a queue-based reference model predicts dispatches and status; a negedge monitor checks dispatches.
module tb_rtob_timed_queue;
  localparam int DL    = 32;
  localparam int TL    = 64;
  localparam int DEPTH = 16;
  localparam int AL    = 4;
  localparam int FT    = 14;
  localparam int EW    = TL + DL;

  logic          clk = 1'b0;
  logic          reset_n, flush, auto_start, late_mode, error_clear;
  logic [TL-1:0] counter;
  logic [AL:0]   level;
  logic          empty, full, overflow_error, timestamp_error, order_error;
  logic [EW-1:0] overflow_error_data, timestamp_error_data, order_error_data;

  always #5 clk = ~clk;

  rtob_timed_queue_if #(.DATA_LEN(DL), .TS_LEN(TL)) bus ();

  rtob_timed_queue #(.DATA_LEN(DL), .TS_LEN(TL), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .flush                (flush),
    .auto_start           (auto_start),
    .late_mode            (late_mode),
    .error_clear          (error_clear),
    .counter              (counter),
    .bus                  (bus),
    .level                (level),
    .empty                (empty),
    .full                 (full),
    .overflow_error       (overflow_error),
    .timestamp_error      (timestamp_error),
    .order_error          (order_error),
    .overflow_error_data  (overflow_error_data),
    .timestamp_error_data (timestamp_error_data),
    .order_error_data     (order_error_data)
  );

  typedef struct {
    logic [TL-1:0] ts;
    logic [DL-1:0] data;
  } ent_t;

  typedef struct {
    logic [TL-1:0] ts;
    logic [DL-1:0] data;
    bit            late;
    int            due;
  } exp_t;

  ent_t          mq[$];
  exp_t          exp_q[$];
  logic [TL-1:0] m_last;
  bit            m_last_vld;
  bit            m_flag [3];
  logic [EW-1:0] m_dat [3];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_last_vld = 1'b0;
    m_last     = '0;
    for (int k = 0; k < 3; k++) begin
      m_flag[k] = 1'b0;
      m_dat[k]  = '0;
    end
  endtask

  task automatic emit(input ent_t h, input bit lt);
    exp_t e;
    e.ts   = h.ts;
    e.data = h.data;
    e.late = lt;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // One clock of the reference behaviour, from the values the DUT will sample at the next edge.
  task automatic model_eval();
    bit            evt [3];
    logic [EW-1:0] edat [3];
    ent_t          h;
    ent_t          n;
    bit            rdy;
    if (flush) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      evt[k]  = 1'b0;
      edat[k] = '0;
    end
    rdy = (mq.size() < FT);
    if (auto_start && mq.size() > 0 && counter >= mq[0].ts) begin
      h = mq.pop_front();
      if (counter == h.ts) emit(h, 1'b0);
      else begin
        evt[1]  = 1'b1;
        edat[1] = {h.ts, h.data};
        if (late_mode) emit(h, 1'b1);
      end
    end
    if (bus.in_valid) begin
      if (!rdy) begin
        evt[0]  = 1'b1;
        edat[0] = {bus.in_timestamp, bus.in_data};
      end else if (m_last_vld && bus.in_timestamp < m_last) begin
        evt[2]  = 1'b1;
        edat[2] = {bus.in_timestamp, bus.in_data};
      end else begin
        n.ts   = bus.in_timestamp;
        n.data = bus.in_data;
        mq.push_back(n);
        m_last     = bus.in_timestamp;
        m_last_vld = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (evt[k]) begin
        if (!m_flag[k] || error_clear) m_dat[k] = edat[k];
        m_flag[k] = 1'b1;
      end else if (error_clear) begin
        m_flag[k] = 1'b0;
      end
    end
  endtask

  task automatic check_status();
    chk("level", 128'(level), 128'(mq.size()));
    chk("in_ready", 128'(bus.in_ready), 128'(mq.size() < FT));
    chk("full", 128'(full), 128'(mq.size() >= FT));
    chk("empty", 128'(empty), 128'(mq.size() == 0));
    chk("overflow_error", 128'(overflow_error), 128'(m_flag[0]));
    chk("timestamp_error", 128'(timestamp_error), 128'(m_flag[1]));
    chk("order_error", 128'(order_error), 128'(m_flag[2]));
    chk("overflow_error_data", 128'(overflow_error_data), 128'(m_dat[0]));
    chk("timestamp_error_data", 128'(timestamp_error_data), 128'(m_dat[1]));
    chk("order_error_data", 128'(order_error_data), 128'(m_dat[2]));
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic drive(input logic v, input logic [TL-1:0] ts, input logic [DL-1:0] d);
    bus.in_valid     = v;
    bus.in_timestamp = ts;
    bus.in_data      = d;
  endtask

  task automatic do_flush();
    drive(1'b0, '0, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_reset_async();
    reset_n = 1'b0;
    model_clear();
    exp_q.delete();
    #1;
    check_status();
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_late", 128'(bus.out_late), 128'(0));
    chk("rst_out_ts", 128'(bus.out_timestamp), 128'(0));
    chk("rst_out_data", 128'(bus.out_data), 128'(0));
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL out_missing actual=none required=ts %0d due cycle %0d", e.ts, e.due);
    end
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_spurious actual=out_valid=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_cycle", 128'(cyc), 128'(e.due));
        chk("out_timestamp", 128'(bus.out_timestamp), 128'(e.ts));
        chk("out_data", 128'(bus.out_data), 128'(e.data));
        chk("out_late", 128'(bus.out_late), 128'(e.late));
        n_out++;
      end
    end
  end

  initial begin
    logic [TL-1:0] ts;
    flush = 1'b0; auto_start = 1'b0; late_mode = 1'b0; error_clear = 1'b0;
    counter = '0;
    drive(1'b0, '0, '0);
    do_reset_async();

    // Equal timestamps: second of the pair goes out late or is dropped, per late_mode.
    for (int lm = 1; lm >= 0; lm--) begin
      do_flush();
      auto_start = 1'b1;
      late_mode  = 1'(lm);
      counter = 64'd90; drive(1'b1, 64'd100, 32'hA); step();
      counter = 64'd91; drive(1'b1, 64'd105, 32'hB); step();
      counter = 64'd92; drive(1'b1, 64'd105, 32'hC); step();
      drive(1'b0, '0, '0);
      for (int c = 93; c <= 110; c++) begin
        counter = 64'(c);
        step();
      end
      chk("eq_ts_error", 128'(timestamp_error), 128'(1));
      chk("eq_ts_error_data", 128'(timestamp_error_data), {32'h0, 64'd105, 32'hC});
    end

    // Entry already stale when dispatch is enabled.
    do_flush();
    auto_start = 1'b0;
    counter = 64'd55; drive(1'b1, 64'd50, 32'hD0050); step();
    drive(1'b0, '0, '0);
    counter = 64'd60; step(); step();
    auto_start = 1'b1; late_mode = 1'b0; step(); step();
    chk("stale_ts_error_data", 128'(timestamp_error_data), {32'h0, 64'd50, 32'hD0050});

    // Fill to threshold, overflow twice, then pop at and just below the threshold.
    do_flush();
    auto_start = 1'b0;
    for (int i = 0; i < FT; i++) begin
      drive(1'b1, 64'(1000 + i), 32'(i)); step();
    end
    drive(1'b1, 64'd999, 32'h999); step();
    drive(1'b1, 64'd2000, 32'h2000); step();
    chk("ovf_data_first", 128'(overflow_error_data), {32'h0, 64'd999, 32'h999});
    auto_start = 1'b1;
    counter = 64'd1000; drive(1'b1, 64'd2001, 32'h2001); step();
    counter = 64'd1001; drive(1'b1, 64'd2002, 32'h2002); step();
    drive(1'b0, '0, '0); auto_start = 1'b0; step();

    // Order violation and clear colliding with a new violation.
    do_flush();
    drive(1'b1, 64'd200, 32'h200); step();
    drive(1'b1, 64'd150, 32'h150); step();
    chk("order_level", 128'(level), 128'(1));
    error_clear = 1'b1;
    drive(1'b1, 64'd100, 32'h100); step();
    error_clear = 1'b0;
    drive(1'b0, '0, '0); step();
    chk("order_recapture", 128'(order_error_data), {32'h0, 64'd100, 32'h100});

    // Randomised traffic.
    do_flush();
    counter = 64'd5000;
    for (int n = 0; n < 2500; n++) begin
      if (n % 250 == 0) late_mode = 1'($urandom_range(0, 1));
      auto_start  = ($urandom_range(0, 19) != 0);
      error_clear = ($urandom_range(0, 19) == 0);
      flush       = ($urandom_range(0, 99) == 0);
      counter     = counter + 64'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 9) == 0) ts = counter - 64'($urandom_range(0, 5));
        else                           ts = counter + 64'($urandom_range(0, 12));
        drive(1'b1, ts, $urandom());
      end else begin
        drive(1'b0, '0, '0);
      end
      step();
    end
    flush = 1'b0; error_clear = 1'b0;

    // Asynchronous reset while a dispatch strobe is on the bus.
    do_flush();
    auto_start = 1'b0; counter = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'(300 + i), 32'(i)); step();
    end
    drive(1'b0, '0, '0);
    auto_start = 1'b1; counter = 64'd300; step();
    do_reset_async();
    chk("reset_kills_strobe", 128'(bus.out_valid), 128'(0));
    for (int i = 1; i <= 6; i++) begin
      counter = 64'(300 + i); step();
    end

    chk("exp_drained", 128'(exp_q.size()), 128'(0));
    chk("outputs_seen", 128'(n_out > 20), 128'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
